// File: rtl/ps2_frame_receiver.sv
// ----------------------------------------------------------------------------
// ps2_frame_receiver : PS/2 device-to-host frame receiver with kclk glitch filter
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ps2_frame_receiver #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       kclk_i,
  input  logic       kdata_i,
  output logic [7:0] keycode_o,
  output logic       keycode_valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o
);

  localparam int FCW = $clog2(FILTER_LEN);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_e;

  logic           kclk_meta_q, kclk_s_q, kdata_meta_q, kdata_s_q;
  logic           kclk_f_q, kclk_f_d, kclk_f_dly_q, fall_q;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;

  state_e         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           par_q, par_d;
  logic [TCW-1:0] tmo_q, tmo_d, tmo_inc;
  logic [7:0]     keycode_q, keycode_d;
  logic           valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      kclk_meta_q  <= 1'b1;
      kclk_s_q     <= 1'b1;
      kdata_meta_q <= 1'b1;
      kdata_s_q    <= 1'b1;
      kclk_f_q     <= 1'b1;
      kclk_f_dly_q <= 1'b1;
      filt_cnt_q   <= '0;
      fall_q       <= 1'b0;
    end else begin
      kclk_meta_q  <= kclk_i;
      kclk_s_q     <= kclk_meta_q;
      kdata_meta_q <= kdata_i;
      kdata_s_q    <= kdata_meta_q;
      kclk_f_q     <= kclk_f_d;
      kclk_f_dly_q <= kclk_f_q;
      filt_cnt_q   <= filt_cnt_d;
      fall_q       <= kclk_f_dly_q & ~kclk_f_q;
    end
  end

  // The filtered level only moves after FILTER_LEN consecutive mismatching cycles.
  always_comb begin
    kclk_f_d   = kclk_f_q;
    filt_cnt_d = '0;
    if (kclk_s_q != kclk_f_q) begin
      if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
        kclk_f_d   = kclk_s_q;
        filt_cnt_d = '0;
      end else begin
        filt_cnt_d = filt_cnt_q + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      keycode_q <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      keycode_q <= keycode_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    keycode_d = keycode_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    tmo_inc   = tmo_q + TCW'(1);
    tmo_d     = (state_q == S_IDLE) ? '0 : tmo_inc;

    // A clock fall is always serviced, even in the cycle the timeout would fire.
    if (fall_q) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (!kdata_s_q) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shreg_d   = {kdata_s_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          par_d   = kdata_s_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!kdata_s_q) begin
            ferr_d = 1'b1;
          end else if (^{shreg_q, par_q}) begin
            keycode_d = shreg_q;
            valid_d   = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if ((state_q != S_IDLE) && (tmo_inc == TCW'(TIMEOUT_CYCLES))) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      shreg_d   = '0;
      tmo_d     = '0;
      ferr_d    = 1'b1;
    end
  end

  assign keycode_o       = keycode_q;
  assign keycode_valid_o = valid_q;
  assign parity_err_o    = perr_q;
  assign frame_err_o     = ferr_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_frame_receiver.sv
// ----------------------------------------------------------------------------
// tb_ps2_frame_receiver : directed PS/2 frames with a scoreboard-checked monitor
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_frame_receiver;

  localparam int FL   = 4;
  localparam int TMO  = 400;
  localparam int HALF = 40;

  localparam int K_VALID = 0;
  localparam int K_PERR  = 1;
  localparam int K_FERR  = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       kclk  = 1'b1;
  logic       kdata = 1'b1;
  logic [7:0] keycode;
  logic       kv, pe, fe;

  ps2_frame_receiver #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .kclk_i         (kclk),
    .kdata_i        (kdata),
    .keycode_o      (keycode),
    .keycode_valid_o(kv),
    .parity_err_o   (pe),
    .frame_err_o    (fe)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic [7:0] code;
    longint     at;
  } exp_t;

  exp_t   sbq[$];
  int     errors = 0;
  int     checks = 0;
  longint last_n = 0;

  function automatic void check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endfunction

  // Monitor: every output pulse is matched against the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && (kv || pe || fe)) begin
      exp_t e;
      int   k;
      k = kv ? K_VALID : (pe ? K_PERR : K_FERR);
      check("single_pulse", int'(kv) + int'(pe) + int'(fe), 1);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: kind %0d keycode 0x%0h at cycle %0d, none expected", k, keycode, cyc);
      end else begin
        e = sbq.pop_front();
        check("pulse_kind", k, e.kind);
        check("pulse_keycode", keycode, e.code);
        if (e.at != 0) check("pulse_cycle", cyc, e.at);
      end
    end
  end

  // Drive one bit: data settles while kclk is high, then kclk falls (edge N = cyc+1).
  task automatic put_bit(input logic b, input bit glitch);
    @(negedge clk);
    kdata = b;
    if (glitch) begin
      repeat (HALF / 2) @(negedge clk);
      kclk = 1'b0;
      repeat (FL - 1) @(negedge clk);
      kclk = 1'b1;
      repeat (HALF - HALF / 2 - (FL - 1)) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    kclk   = 1'b0;
    last_n = cyc + 1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int nbits, input bit glitch,
                            input int exp_kind, input logic [7:0] exp_code);
    logic [10:0] f;
    f = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      put_bit(f[i], glitch);
      if (i == 10) sbq.push_back('{exp_kind, exp_code, last_n + FL + 3});
      repeat (HALF) @(negedge clk);
      kclk = 1'b1;
    end
    @(negedge clk);
    kdata = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected pulses never seen, expected 0 outstanding", name, sbq.size());
      sbq.delete();
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_keycode"}, keycode, 8'h00);
    check({tag, "_valid"}, kv, 0);
    check({tag, "_parity_err"}, pe, 0);
    check({tag, "_frame_err"}, fe, 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 0x1C: bits 0,0,1,1,1,0,0,0 -> three ones, odd parity bit 0
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, K_VALID, 8'h1C);
    drain("good_1C");

    // Back-to-back: 0xF0 (four ones, parity 1) then 0x1C with no extra gap
    send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0, K_VALID, 8'hF0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, K_VALID, 8'h1C);
    drain("back_to_back");
    check("hold_after_b2b", keycode, 8'h1C);

    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0, K_PERR, 8'h1C);
    drain("parity_err");
    check("hold_after_perr", keycode, 8'h1C);

    send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0, K_FERR, 8'h1C);
    drain("stop_err");

    // 0x5A: four ones, parity 1; FL-1 cycle low glitches in every high phase
    send_frame(8'h5A, 1'b1, 1'b1, 11, 1'b1, K_VALID, 8'h5A);
    drain("glitch_5A");

    // Start + 4 data bits, then kclk stays high: timeout fires TMO after the last fall's slot
    send_frame(8'h29, 1'b0, 1'b1, 5, 1'b0, K_VALID, 8'h00);
    sbq.push_back('{K_FERR, 8'h5A, last_n + FL + 3 + TMO});
    drain("timeout");

    // 0x29: three ones, parity 0
    send_frame(8'h29, 1'b0, 1'b1, 11, 1'b0, K_VALID, 8'h29);
    drain("after_timeout_29");

    // Reset after start + 5 data bits
    send_frame(8'h55, 1'b1, 1'b1, 6, 1'b0, K_VALID, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs("midframe_reset");
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 0x76: five ones, parity 0
    send_frame(8'h76, 1'b0, 1'b1, 11, 1'b0, K_VALID, 8'h76);
    drain("after_reset_76");
    check("final_keycode", keycode, 8'h76);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
